// File: rtl/paralelo_serial_tx_pkg.sv
// Shared definitions for the Phy serial transmit path: comma symbol,
// bit-counter geometry and FSM state encodings (kept in step with Phy_rx).
package paralelo_serial_tx_pkg;

   // Idle / alignment symbol (K28.5-style comma)
   localparam logic [7:0] COMMA_SYMBOL = 8'hBC;

   // A byte is 8 bit slots, so a 3-bit counter wraps naturally at the boundary
   localparam int                    BIT_CNT_W = 3;
   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = 3'd7;

   // Two-state FSM encodings, legacy-compatible constants
   localparam logic [0:0] ST_SYNC   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   // With a single sync comma the reset byte itself is the whole sync sequence
   function automatic logic [0:0] reset_state(input int sync_commas);
      return (sync_commas == 1) ? ST_ACTIVE : ST_SYNC;
   endfunction

endpackage

// File: rtl/paralelo_serial_tx_ps_bit_shifter.sv
// Byte-to-bit shifter: holds the byte being serialised and its bit index,
// drives the registered serial bit MSB first and flags the last bit slot.
module ps_bit_shifter
   import paralelo_serial_tx_pkg::*;
#(
   parameter logic [7:0] COMMA = COMMA_SYMBOL
) (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic [7:0] next_byte,
   output logic       serial_bit,
   output logic       boundary
);

   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [7:0]           cur_byte;

   // Last bit of the current byte is on its way out; next_byte is taken now
   assign boundary = (bit_cnt == LAST_BIT);

   // Shift one bit per edge and reload the byte register at each byte boundary
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         bit_cnt    <= '0;
         cur_byte   <= COMMA;
         serial_bit <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop here samples pre-edge values of the others
         serial_bit <= cur_byte[LAST_BIT - bit_cnt];
         bit_cnt    <= bit_cnt + 1'b1;
         if (boundary) begin
            cur_byte <= next_byte;
         end
      end
   end

endmodule

// File: rtl/paralelo_serial_tx.sv
// Phy transmit serialiser: sends SYNC_COMMAS alignment commas after reset,
// then accepted data bytes MSB first, filling empty byte slots with commas.
module paralelo_serial_tx
   import paralelo_serial_tx_pkg::*;
#(
   parameter int         SYNC_COMMAS = 4,
   parameter logic [7:0] COMMA       = COMMA_SYMBOL
) (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic [7:0] data_in_PS,
   input  logic       valid_PS,
   output logic       ready_PS,
   output logic       data_out_PS,
   output logic       active_PS,
   output logic       err_comma_PS
);

   localparam logic [0:0] RESET_STATE = reset_state(SYNC_COMMAS);
   localparam logic [4:0] SYNC_TARGET = 5'(SYNC_COMMAS);

   logic [0:0] state;
   logic [0:0] state_next;
   logic [3:0] comma_cnt;
   logic [4:0] comma_cnt_inc;
   logic       boundary;
   logic       accept;
   logic [7:0] next_byte;

   // The only acceptance point is the last bit slot of a byte while active
   assign ready_PS      = (state == ST_ACTIVE) & boundary;
   assign accept        = ready_PS & valid_PS;
   assign next_byte     = accept ? data_in_PS : COMMA;
   assign comma_cnt_inc = {1'b0, comma_cnt} + 5'd1;

   ps_bit_shifter #(
      .COMMA (COMMA)
   ) u_shifter (
      .clk_32f    (clk_32f),
      .reset_L    (reset_L),
      .next_byte  (next_byte),
      .serial_bit (data_out_PS),
      .boundary   (boundary)
   );

   // Next-state logic: leave SYNC once the last sync comma has been loaded
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred
      state_next = state;
      case (state)
         ST_SYNC: begin
            if (boundary && (comma_cnt_inc == SYNC_TARGET)) begin
               state_next = ST_ACTIVE;
            end
         end
         ST_ACTIVE: state_next = ST_ACTIVE;
         default:   state_next = ST_SYNC;
      endcase
   end

   // FSM, sync comma count, active flag and comma-in-data error pulse
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state        <= RESET_STATE;
         comma_cnt    <= 4'd1;
         active_PS    <= 1'b0;
         err_comma_PS <= 1'b0;
      end else begin
         state        <= state_next;
         active_PS    <= (state_next == ST_ACTIVE);
         err_comma_PS <= accept && (data_in_PS == COMMA);
         if ((state == ST_SYNC) && boundary) begin
            comma_cnt <= comma_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Self-checking bench for paralelo_serial_tx: a slot-level model predicts
// every output each cycle; directed literals pin the sync, latency and error timing.
module tb_paralelo_serial_tx;

   localparam int         SYNC  = 4;
   localparam logic [7:0] COMMA = 8'hBC;
   localparam int         HIST  = 8192;

   logic       clk_32f;
   logic       reset_L;
   logic [7:0] data_in_PS;
   logic       valid_PS;
   logic       ready_PS;
   logic       data_out_PS;
   logic       active_PS;
   logic       err_comma_PS;

   int vectors     = 0;
   int miscompares = 0;

   // model state: edges since reset release, byte carried by each 8-edge slot
   int         n = 0;
   int         last_accept_n = -1;
   logic [7:0] slot_byte [0:HIST/8];
   logic       err_at    [0:HIST];

   // sampled history, index = edges since release
   logic dout_s [0:HIST];
   logic act_s  [0:HIST];
   logic rdy_s  [0:HIST];
   logic err_s  [0:HIST];

   logic [7:0] offered [$];

   paralelo_serial_tx #(
      .SYNC_COMMAS (SYNC),
      .COMMA       (COMMA)
   ) dut (
      .clk_32f      (clk_32f),
      .reset_L      (reset_L),
      .data_in_PS   (data_in_PS),
      .valid_PS     (valid_PS),
      .ready_PS     (ready_PS),
      .data_out_PS  (data_out_PS),
      .active_PS    (active_PS),
      .err_comma_PS (err_comma_PS)
   );

   initial clk_32f = 1'b0;
   always #5 clk_32f = ~clk_32f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t n=%0d)", name, act, exp, $time, n);
      end
   endtask

   // Slot model: slot k occupies edges 8k+1..8k+8 and is chosen at edge 8k.
   // Slots below SYNC are commas; later slots carry the byte offered at edge 8k, else a comma.
   always @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         n            = 0;
         slot_byte[0] = COMMA;
         err_at[0]    = 1'b0;
      end else begin
         n = n + 1;
         if (n <= HIST) begin
            err_at[n] = 1'b0;
            if (n % 8 == 0) begin
               if ((n / 8 >= SYNC) && valid_PS) begin
                  slot_byte[n/8] = data_in_PS;
                  err_at[n]      = (data_in_PS == COMMA);
                  last_accept_n  = n;
               end else begin
                  slot_byte[n/8] = COMMA;
               end
            end
         end
      end
   end

   function automatic logic exp_dout(input int e);
      logic [7:0] b;
      if (e == 0) return 1'b0;
      b = slot_byte[(e-1)/8];
      return b[7 - ((e-1) % 8)];
   endfunction

   // Compare every output on each falling edge, away from the active edge
   always @(negedge clk_32f) begin
      if (!reset_L) begin
         check("reset_dout",   32'(data_out_PS),  32'd0);
         check("reset_active", 32'(active_PS),    32'd0);
         check("reset_err",    32'(err_comma_PS), 32'd0);
         check("reset_ready",  32'(ready_PS),     32'd0);
      end else if (n <= HIST) begin
         check("dout",   32'(data_out_PS),  32'(exp_dout(n)));
         check("active", 32'(active_PS),    32'((n >= 1) && (n >= (SYNC-1)*8)));
         check("err",    32'(err_comma_PS), 32'((n >= 1) ? err_at[n] : 1'b0));
         check("ready",  32'(ready_PS),     32'(((n+1) % 8 == 0) && (n+1 >= SYNC*8)));
         dout_s[n] = data_out_PS;
         act_s[n]  = active_PS;
         rdy_s[n]  = ready_PS;
         err_s[n]  = err_comma_PS;
      end
   end

   function automatic logic [31:0] bits(input int from, input int cnt);
      logic [31:0] r = '0;
      for (int i = 0; i < cnt; i++) r = {r[30:0], dout_s[from+i]};
      return r;
   endfunction

   function automatic int first_active(input int lim);
      for (int i = 1; i <= lim; i++) if (act_s[i] === 1'b1) return i;
      return -1;
   endfunction

   function automatic int first_ready(input int lim);
      for (int i = 0; i <= lim; i++) if (rdy_s[i] === 1'b1) return i + 1;
      return -1;
   endfunction

   task automatic wait_edge(input int target);
      int guard = 0;
      while ((n < target) && (guard < 20000)) begin
         @(posedge clk_32f); #1;
         guard++;
      end
      if (n < target) check("wait_timeout", 32'(n), 32'(target));
   endtask

   task automatic settle();
      @(negedge clk_32f); #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int tries = 0;
      data_in_PS = b;
      valid_PS   = 1'b1;
      while (tries < 64) begin
         @(negedge clk_32f);
         if (ready_PS === 1'b1) break;
         tries++;
      end
      if (tries >= 64) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: byte %0h never accepted", b);
         valid_PS = 1'b0;
      end else begin
         @(posedge clk_32f); #1;
         valid_PS = 1'b0;
      end
   endtask

   task automatic check_sync();
      check("sync_bits",    bits(1, 32),        32'hBCBC_BCBC);
      check("active_rise",  32'(first_active(40)), 32'd24);
      check("first_ready",  32'(first_ready(39)),  32'd32);
   endtask

   initial begin
      int e;
      int kstart;
      int kend;
      logic [7:0] rx [$];
      logic [7:0] b;

      reset_L    = 1'b0;
      valid_PS   = 1'b0;
      data_in_PS = 8'h00;
      repeat (3) @(posedge clk_32f);
      #1 reset_L = 1'b1;

      // Sync commas, then a byte held pending from edge 20 accepted only at edge 32
      wait_edge(20);
      data_in_PS = 8'hA5;
      valid_PS   = 1'b1;
      wait_edge(32);
      valid_PS   = 1'b0;
      wait_edge(56);
      settle();
      check_sync();
      check("a5_accept_edge", 32'(last_accept_n), 32'd32);
      check("a5_bits",        bits(33, 8),       32'h0000_00A5);
      check("idle_fill",      bits(41, 16),      32'h0000_BCBC);

      // Back-to-back bytes with no gap comma
      send_byte(8'h01);
      e = last_accept_n;
      send_byte(8'hFF);
      send_byte(8'h80);
      check("b2b_spacing", 32'(last_accept_n - e), 32'd16);
      wait_edge(e + 24);
      settle();
      check("b2b_bits", bits(e + 1, 24), 32'h0001_FF80);

      // Comma as data: one-cycle error pulse, byte still transmitted
      send_byte(8'hBC);
      e = last_accept_n;
      wait_edge(e + 9);
      settle();
      check("err_before", 32'(err_s[e-1]), 32'd0);
      check("err_pulse",  32'(err_s[e]),   32'd1);
      check("err_after",  32'(err_s[e+1]), 32'd0);
      check("bc_bits",    bits(e + 1, 8),  32'h0000_00BC);

      // Reset three bits into a data byte: async clear, full sync repeats
      send_byte(8'hC3);
      e = last_accept_n;
      wait_edge(e + 3);
      check("c3_partial", bits(e + 1, 2), 32'd3);
      #2 reset_L = 1'b0;
      #1;
      check("async_dout",   32'(data_out_PS), 32'd0);
      check("async_active", 32'(active_PS),   32'd0);
      repeat (2) @(posedge clk_32f);
      #1 reset_L = 1'b1;
      wait_edge(40);
      settle();
      check_sync();

      // Random stream with random idle gaps; recover bytes from the line, dropping commas
      e = n;
      for (int i = 0; i < 200; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == COMMA) b = 8'h3C;
         repeat ($urandom_range(0, 2) * 8) begin
            @(posedge clk_32f); #1;
         end
         offered.push_back(b);
         send_byte(b);
      end
      wait_edge(last_accept_n + 10);
      settle();
      kstart = e / 8 + 1;
      kend   = last_accept_n / 8;
      for (int k = kstart; k <= kend; k++) begin
         b = bits(8*k + 1, 8) & 8'hFF;
         if (b != COMMA) rx.push_back(b);
      end
      check("loop_count", 32'(rx.size()), 32'(offered.size()));
      for (int i = 0; i < offered.size() && i < rx.size(); i++) begin
         check($sformatf("loop_byte%0d", i), 32'(rx[i]), 32'(offered[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
